// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit and its datapath:
// FSM states, instruction classes, mux selects and opcode constants.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsNone   = 4'd0,
        ClsR      = 4'd1,
        ClsIArith = 4'd2,
        ClsLoad   = 4'd3,
        ClsStore  = 4'd4,
        ClsBranch = 4'd5,
        ClsJal    = 4'd6,
        ClsJalr   = 4'd7,
        ClsLui    = 4'd8,
        ClsAuipc  = 4'd9
    } inst_cls_e;

    localparam logic [1:0] AluAdd  = 2'b00;
    localparam logic [1:0] AluSub  = 2'b01;
    localparam logic [1:0] AluFunc = 2'b10;
    localparam logic [1:0] AluImm  = 2'b11;

    localparam logic [1:0] PcPlus4  = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJalr   = 2'b10;

    localparam logic [1:0] WbAlu  = 2'b00;
    localparam logic [1:0] WbMem  = 2'b01;
    localparam logic [1:0] WbLink = 2'b10;
    localparam logic [1:0] WbImm  = 2'b11;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcIArith = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps opcode/funct fields to an
// instruction class and flags encodings the control unit does not support.
module mc_decode
    import mc_ctrl_pkg::*;
#(
    parameter bit EXT_JALR = 1'b1
) (
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] cls_o,
    output logic       illegal_o
);

    logic f7_ok;
    logic f3_sub_ok;
    logic is_shift;

    assign f7_ok     = (funct7_i == 7'h00) || (funct7_i == 7'h20);
    assign f3_sub_ok = (funct3_i == 3'b000) || (funct3_i == 3'b101);
    assign is_shift  = (funct3_i == 3'b001) || (funct3_i == 3'b101);

    always_comb begin
        cls_o     = ClsNone;
        illegal_o = 1'b0;
        case (opcode_i)
            OpcR: begin
                cls_o     = ClsR;
                illegal_o = !f7_ok || ((funct7_i == 7'h20) && !f3_sub_ok);
            end
            OpcIArith: begin
                cls_o     = ClsIArith;
                illegal_o = is_shift && !f7_ok;
            end
            OpcLoad:   cls_o = ClsLoad;
            OpcStore:  cls_o = ClsStore;
            OpcBranch: cls_o = ClsBranch;
            OpcJal:    cls_o = ClsJal;
            OpcJalr: begin
                if (EXT_JALR) cls_o = ClsJalr;
                else          illegal_o = 1'b1;
            end
            OpcLui: begin
                if (EXT_JALR) cls_o = ClsLui;
                else          illegal_o = 1'b1;
            end
            OpcAuipc: begin
                if (EXT_JALR) cls_o = ClsAuipc;
                else          illegal_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// variable-latency memory handshake, timeout trap and sticky trap causes.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter bit          EXT_JALR    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_is_fetch,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [2:0] state,
    output logic       illegal,
    output logic       mem_timeout
);

    localparam int unsigned    CntW     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLimit = CntW'(MEM_TIMEOUT);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;

    logic [3:0] cls_raw;
    inst_cls_e  cls;
    logic       dec_illegal;
    logic       waiting;
    logic       expired;

    mc_decode #(
        .EXT_JALR (EXT_JALR)
    ) u_decode (
        .opcode_i  (opcode),
        .funct3_i  (funct3),
        .funct7_i  (funct7),
        .cls_o     (cls_raw),
        .illegal_o (dec_illegal)
    );

    assign cls     = inst_cls_e'(cls_raw);
    assign waiting = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
    // A ready on the boundary cycle completes the access instead of trapping.
    assign expired = waiting && (cnt_q == CntLimit);

    always_comb begin
        state_d   = state_q;
        cnt_d     = waiting ? cnt_q + CntW'(1) : '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                if (dec_illegal) begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                unique case (cls)
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsBranch:         state_d = StFetch;
                    default:           state_d = StWb;
                endcase
            end
            StMem: begin
                if (mem_ready) state_d = (cls == ClsLoad) ? StWb : StFetch;
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
        if (expired) begin
            state_d   = StTrap;
            timeout_d = 1'b1;
        end
        if (state_d == StTrap) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Reset forces every output low in the same cycle, abandoning any access.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = PcPlus4;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = AluAdd;
        reg_write    = 1'b0;
        wb_sel       = WbAlu;
        state        = 3'd0;
        illegal      = 1'b0;
        mem_timeout  = 1'b0;
        if (!rst) begin
            state       = state_q;
            illegal     = illegal_q;
            mem_timeout = timeout_q;
            unique case (state_q)
                StFetch: begin
                    mem_req      = 1'b1;
                    mem_is_fetch = 1'b1;
                    ir_write     = mem_ready;
                    pc_write     = mem_ready;
                end
                StExec: begin
                    unique case (cls)
                        ClsR: alu_op = AluFunc;
                        ClsIArith: begin
                            alu_src_b = 1'b1;
                            alu_op    = AluImm;
                        end
                        ClsLoad, ClsStore: alu_src_b = 1'b1;
                        ClsBranch: begin
                            alu_op   = AluSub;
                            pc_sel   = PcBranch;
                            pc_write = branch_taken;
                        end
                        ClsJal: begin
                            pc_sel   = PcBranch;
                            pc_write = 1'b1;
                        end
                        ClsJalr: begin
                            alu_src_b = 1'b1;
                            pc_sel    = PcJalr;
                            pc_write  = 1'b1;
                        end
                        ClsAuipc: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    mem_req = 1'b1;
                    mem_we  = (cls == ClsStore);
                end
                StWb: begin
                    reg_write = 1'b1;
                    unique case (cls)
                        ClsLoad:         wb_sel = WbMem;
                        ClsJal, ClsJalr: wb_sel = WbLink;
                        ClsLui:          wb_sel = WbImm;
                        default:         wb_sel = WbAlu;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed scoreboard bench for mc_control_fsm: two instances (JALR extension
// on with a short timeout, extension off) checked cycle by cycle.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       branch_taken;
    logic       mem_ready;

    logic [2:0] st   [2];
    logic       req  [2];
    logic       we   [2];
    logic       isf  [2];
    logic       irw  [2];
    logic       pcw  [2];
    logic [1:0] pcs  [2];
    logic       sa   [2];
    logic       sb   [2];
    logic [1:0] aop  [2];
    logic       rw   [2];
    logic [1:0] wbs  [2];
    logic       ill  [2];
    logic       tmo  [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          dut;
        logic [18:0] v;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mc_control_fsm #(
        .MEM_TIMEOUT (4),
        .EXT_JALR    (1'b1)
    ) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (req[0]),
        .mem_we       (we[0]),
        .mem_is_fetch (isf[0]),
        .ir_write     (irw[0]),
        .pc_write     (pcw[0]),
        .pc_sel       (pcs[0]),
        .alu_src_a    (sa[0]),
        .alu_src_b    (sb[0]),
        .alu_op       (aop[0]),
        .reg_write    (rw[0]),
        .wb_sel       (wbs[0]),
        .state        (st[0]),
        .illegal      (ill[0]),
        .mem_timeout  (tmo[0])
    );

    mc_control_fsm #(
        .MEM_TIMEOUT (255),
        .EXT_JALR    (1'b0)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (req[1]),
        .mem_we       (we[1]),
        .mem_is_fetch (isf[1]),
        .ir_write     (irw[1]),
        .pc_write     (pcw[1]),
        .pc_sel       (pcs[1]),
        .alu_src_a    (sa[1]),
        .alu_src_b    (sb[1]),
        .alu_op       (aop[1]),
        .reg_write    (rw[1]),
        .wb_sel       (wbs[1]),
        .state        (st[1]),
        .illegal      (ill[1]),
        .mem_timeout  (tmo[1])
    );

    // {state, req, we, is_fetch, ir_write, pc_write, pc_sel, a, b, alu_op, reg_write,
    //  wb_sel, illegal, mem_timeout}
    function automatic logic [18:0] obs(input int i);
        return {st[i], req[i], we[i], isf[i], irw[i], pcw[i], pcs[i], sa[i], sb[i], aop[i],
                rw[i], wbs[i], ill[i], tmo[i]};
    endfunction

    function automatic logic [18:0] mk(input logic [2:0] s, input logic rq, input logic w,
                                       input logic f, input logic ir, input logic pw,
                                       input logic [1:0] ps, input logic a, input logic b,
                                       input logic [1:0] op, input logic r,
                                       input logic [1:0] wb, input logic il, input logic to);
        return {s, rq, w, f, ir, pw, ps, a, b, op, r, wb, il, to};
    endfunction

    function automatic logic [18:0] f_wait();
        return mk(StFetch, 1, 0, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0);
    endfunction

    function automatic logic [18:0] f_done();
        return mk(StFetch, 1, 0, 1, 1, 1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0);
    endfunction

    function automatic logic [18:0] dec();
        return mk(StDecode, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0);
    endfunction

    function automatic logic [18:0] trap(input logic il, input logic to);
        return mk(StTrap, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, il, to);
    endfunction

    function automatic logic [18:0] wb(input logic [1:0] sel);
        return mk(StWb, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, sel, 0, 0);
    endfunction

    task automatic set_inst(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    // One clock: drive inputs at the falling edge, queue expectations, compare 1 ns later.
    task automatic step(input logic r, input logic rdy, input logic bt, input string tag,
                        input logic [18:0] e0, input bit chk1 = 1'b0,
                        input logic [18:0] e1 = '0);
        @(negedge clk);
        rst          = r;
        mem_ready    = rdy;
        branch_taken = bt;
        sb_q.push_back('{tag, 0, e0});
        if (chk1) sb_q.push_back('{tag, 1, e1});
        #1;
        while (sb_q.size() > 0) begin
            exp_t        x;
            logic [18:0] o;
            x = sb_q.pop_front();
            o = obs(x.dut);
            checks++;
            assert (o === x.v) else begin
                errors++;
                $error("FAIL %s dut%0d: observed %b expected %b", x.tag, x.dut, o, x.v);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        set_inst(7'd0, 3'd0, 7'd0);

        step(1, 1, 0, "reset0", '0, 1'b1, '0);
        step(1, 1, 0, "reset1", '0, 1'b1, '0);

        // add: F D E W
        step(0, 1, 0, "add_f", f_done(), 1'b1, f_done());
        set_inst(7'b0110011, 3'b000, 7'h00);
        step(0, 1, 0, "add_d", dec(), 1'b1, dec());
        step(0, 1, 0, "add_e", mk(StExec, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b10, 0, 2'b00, 0, 0));
        step(0, 1, 0, "add_w", wb(2'b00));

        // lw with two wait cycles in MEM
        step(0, 1, 0, "lw_f", f_done());
        set_inst(7'b0000011, 3'b010, 7'h00);
        step(0, 1, 0, "lw_d", dec());
        step(0, 1, 0, "lw_e", mk(StExec, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00, 0, 0));
        step(0, 0, 0, "lw_m0", mk(StMem, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        step(0, 0, 0, "lw_m1", mk(StMem, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        step(0, 1, 0, "lw_m2", mk(StMem, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        step(0, 1, 0, "lw_w", wb(2'b01));

        // sw: store goes straight back to FETCH
        step(0, 1, 0, "sw_f", f_done());
        set_inst(7'b0100011, 3'b010, 7'h00);
        step(0, 1, 0, "sw_d", dec());
        step(0, 1, 0, "sw_e", mk(StExec, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00, 0, 0));
        step(0, 1, 0, "sw_m", mk(StMem, 1, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0));

        // beq taken then not taken
        step(0, 1, 0, "beq1_f", f_done());
        set_inst(7'b1100011, 3'b000, 7'h00);
        step(0, 1, 0, "beq1_d", dec());
        step(0, 1, 1, "beq1_e", mk(StExec, 0, 0, 0, 0, 1, 2'b01, 0, 0, 2'b01, 0, 2'b00, 0, 0));
        step(0, 1, 0, "beq0_f", f_done());
        step(0, 1, 0, "beq0_d", dec());
        step(0, 1, 0, "beq0_e", mk(StExec, 0, 0, 0, 0, 0, 2'b01, 0, 0, 2'b01, 0, 2'b00, 0, 0));

        // jalr: legal on dut0, illegal on dut1 (extension disabled)
        step(0, 1, 0, "jalr_f", f_done(), 1'b1, f_done());
        set_inst(7'b1100111, 3'b000, 7'h00);
        step(0, 1, 0, "jalr_d", dec(), 1'b1, dec());
        step(0, 1, 0, "jalr_e", mk(StExec, 0, 0, 0, 0, 1, 2'b10, 0, 1, 2'b00, 0, 2'b00, 0, 0),
             1'b1, trap(1, 0));
        step(0, 1, 0, "jalr_w", wb(2'b10), 1'b1, trap(1, 0));

        // jal, lui, auipc, addi
        step(0, 1, 0, "jal_f", f_done(), 1'b1, trap(1, 0));
        set_inst(7'b1101111, 3'b000, 7'h00);
        step(0, 1, 0, "jal_d", dec());
        step(0, 1, 0, "jal_e", mk(StExec, 0, 0, 0, 0, 1, 2'b01, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        step(0, 1, 0, "jal_w", wb(2'b10));
        step(0, 1, 0, "lui_f", f_done());
        set_inst(7'b0110111, 3'b000, 7'h00);
        step(0, 1, 0, "lui_d", dec());
        step(0, 1, 0, "lui_e", mk(StExec, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        step(0, 1, 0, "lui_w", wb(2'b11));
        step(0, 1, 0, "auipc_f", f_done());
        set_inst(7'b0010111, 3'b000, 7'h00);
        step(0, 1, 0, "auipc_d", dec());
        step(0, 1, 0, "auipc_e", mk(StExec, 0, 0, 0, 0, 0, 2'b00, 1, 1, 2'b00, 0, 2'b00, 0, 0));
        step(0, 1, 0, "auipc_w", wb(2'b00));
        step(0, 1, 0, "addi_f", f_done());
        set_inst(7'b0010011, 3'b000, 7'h00);
        step(0, 1, 0, "addi_d", dec());
        step(0, 1, 0, "addi_e", mk(StExec, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b11, 0, 2'b00, 0, 0));
        step(0, 1, 0, "addi_w", wb(2'b00));

        // R-type funct7=0x20 with funct3=001 is illegal
        step(0, 1, 0, "ill_f", f_done());
        set_inst(7'b0110011, 3'b001, 7'h20);
        step(0, 1, 0, "ill_d", dec());
        step(0, 1, 0, "ill_t0", trap(1, 0), 1'b1, trap(1, 0));
        step(0, 1, 0, "ill_t1", trap(1, 0));

        // Timeout: ready stuck low for five FETCH cycles
        step(1, 0, 0, "to_rst", '0, 1'b1, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, "to_fetch", f_wait());
        step(0, 0, 0, "to_trap0", trap(0, 1));
        step(0, 1, 0, "to_trap1", trap(0, 1));

        // Ready on the boundary cycle wins; then reset during a load's MEM
        step(1, 0, 0, "bnd_rst", '0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, "bnd_fetch", f_wait());
        step(0, 1, 0, "bnd_last", f_done());
        set_inst(7'b0000011, 3'b010, 7'h00);
        step(0, 1, 0, "bnd_d", dec());
        step(0, 1, 0, "bnd_e", mk(StExec, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00, 0, 0));
        step(0, 0, 0, "bnd_m", mk(StMem, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0));
        step(1, 0, 0, "mid_rst", '0, 1'b1, '0);
        step(0, 0, 0, "post_rst", f_wait(), 1'b1, f_wait());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
